prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the load byte width.
REQ-002 Parameter ADDR_WIDTH, default 12, SHALL set the fetch and write address width.
REQ-003 Parameter INSTRUCTION_WIDTH, default 16, SHALL be 2*DATA_WIDTH and set the stored word width.
REQ-004 Parameter MEM_DEPTH, default 256, SHALL set the word count, with MEM_DEPTH <= 2^ADDR_WIDTH.
REQ-005 general_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 general_reset  in  1  SHALL be the reset: asynchronous, active-low.
REQ-007 LOAD_START  in  1  SHALL be a one-cycle pulse that begins a load at address 0.
REQ-008 LOAD_DATA  in  DATA_WIDTH  SHALL be the program byte.
REQ-009 LOAD_VALID  in  1 / LOAD_READY  out  1  SHALL form the byte handshake; a transfer occurs when both are 1 on a clock edge.
REQ-010 LOAD_LAST  in  1  SHALL qualify the transferred byte as the final program byte.
REQ-011 FETCH_REQ  in  1 / FETCH_ADDR  in  ADDR_WIDTH  SHALL be the processor PC fetch request.
REQ-012 FETCH_DATA  out  INSTRUCTION_WIDTH / FETCH_VALID  out  1  SHALL return the fetched instruction.
REQ-013 CPU_RESET_OUT  out  1  SHALL be the active-low processor reset, driven to general_reset of the core.
REQ-014 LOAD_COUNT  out  ADDR_WIDTH  SHALL give the number of words written in the current or last load.
REQ-015 LOAD_ERROR  out  1  SHALL flag a failed load.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD_HI, LOAD_LO, RUN and ERROR, plus LOAD_CSUM when the checksum feature is compiled in.
REQ-017 IDLE: CPU_RESET_OUT=0 and LOAD_READY=0; LOAD_START -> LOAD_HI.
REQ-018 LOAD_HI: LOAD_READY=1; a transfer latches the byte as word bits [15:8] -> LOAD_LO, unless LOAD_LAST=1, which -> ERROR (odd byte count).
REQ-019 LOAD_LO: LOAD_READY=1; a transfer writes {hi,byte} at write pointer and increments the pointer and LOAD_COUNT.
REQ-020 LOAD_LO exit: LOAD_LAST=1 -> RUN (or LOAD_CSUM); otherwise -> LOAD_HI.
REQ-021 Overflow: a LOAD_LO transfer that writes address MEM_DEPTH-1 with LOAD_LAST=0 SHALL write the word and -> ERROR.
REQ-022 RUN: CPU_RESET_OUT=1 and LOAD_READY=0; fetches are served.
REQ-023 ERROR: CPU_RESET_OUT=0 and LOAD_ERROR=1; LOAD_READY=0.
REQ-024 LOAD_START in any state SHALL -> LOAD_HI, clear the pointer, LOAD_COUNT and LOAD_ERROR, and drive CPU_RESET_OUT=0 from the next cycle.
REQ-025 LOAD_START coincident with a transfer SHALL take priority; the byte is dropped.
REQ-026 Fetch SHALL be a synchronous read with latency 1: FETCH_REQ at cycle N -> FETCH_VALID=1 and FETCH_DATA=mem[FETCH_ADDR] at N+1.
REQ-027 Fetch outside RUN SHALL yield FETCH_VALID=0 and FETCH_DATA=0.
REQ-028 FETCH_ADDR >= MEM_DEPTH SHALL return FETCH_DATA=0 with FETCH_VALID=1.
REQ-029 Memory contents SHALL persist across LOAD_START; unwritten words hold their prior value.

Reset
REQ-030 With general_reset low: state=IDLE, CPU_RESET_OUT=0, LOAD_READY=0, FETCH_VALID=0, FETCH_DATA=0, LOAD_COUNT=0, LOAD_ERROR=0, pointer=0.
REQ-031 Memory array SHALL not be reset.
REQ-032 Reset mid-load SHALL abort immediately; a fresh LOAD_START is then required.

Configuration
REQ-033 Macro PROG_LOADER_CHECKSUM_EN defined: after the LOAD_LAST word the FSM SHALL enter LOAD_CSUM and accept one byte; if it equals the mod-256 sum of all program bytes -> RUN, else -> ERROR.
REQ-034 Macro undefined: no LOAD_CSUM state and no accumulator; LOAD_LAST -> RUN directly.

Structure
REQ-035 Package pampy_loader_pkg SHALL hold the state enum and the default width constants (8/12/16).
REQ-036 Sub-module prog_mem_ram SHALL implement the array: one synchronous write port and one synchronous read port.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Load bytes 12 34 56 78 (LAST on 78), fetch 0 and 1 -> 0x1234, 0x5678 one cycle after each request; LOAD_COUNT=2; CPU_RESET_OUT rises after the last transfer.
- Load 3 bytes with LAST on the third -> ERROR, LOAD_ERROR=1, CPU_RESET_OUT=0.
- MEM_DEPTH=4, 10 bytes with no LAST -> ERROR after the 8th byte; LOAD_READY=0.
- LOAD_VALID toggling with stalls -> words identical to the stall-free case.
- Reset asserted in LOAD_LO -> all outputs at reset values; fetch in IDLE -> FETCH_VALID=0.
- With PROG_LOADER_CHECKSUM_EN, bytes 01 02 + csum 03 -> RUN; csum 04 -> ERROR.

Source files
------------

// File: rtl/pampy_loader_pkg.sv
// Shared definitions for the program loader: default widths and the loader FSM state encoding.
// The LOAD_CSUM state only exists when PROG_LOADER_CHECKSUM_EN is defined.
package pampy_loader_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_INSTR_WIDTH = 16;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_HI   = 3'd1,
        S_LOAD_LO   = 3'd2,
        S_RUN       = 3'd3,
        S_ERROR     = 3'd4,
        S_LOAD_CSUM = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_HI = 3'd1,
        S_LOAD_LO = 3'd2,
        S_RUN     = 3'd3,
        S_ERROR   = 3'd4
    } state_t;
`endif

endpackage

// File: rtl/prog_mem_ram.sv
// Program memory: one synchronous write port, one synchronous read port.
// Contents are deliberately not reset so a program survives a reload that writes fewer words.
module prog_mem_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: packs byte pairs into words, holds the core in reset until a
// clean load finishes, then serves PC fetches. Define PROG_LOADER_CHECKSUM_EN for a trailing checksum byte.
module prog_loader
    import pampy_loader_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int INSTRUCTION_WIDTH = 2 * DATA_WIDTH,
    parameter int MEM_DEPTH         = 256
) (
    input  logic                         general_clk,
    input  logic                         general_reset,
    input  logic                         LOAD_START,
    input  logic [DATA_WIDTH-1:0]        LOAD_DATA,
    input  logic                         LOAD_VALID,
    output logic                         LOAD_READY,
    input  logic                         LOAD_LAST,
    input  logic                         FETCH_REQ,
    input  logic [ADDR_WIDTH-1:0]        FETCH_ADDR,
    output logic [INSTRUCTION_WIDTH-1:0] FETCH_DATA,
    output logic                         FETCH_VALID,
    output logic                         CPU_RESET_OUT,
    output logic [ADDR_WIDTH-1:0]        LOAD_COUNT,
    output logic                         LOAD_ERROR,
    output logic [2:0]                   DBG_STATE
);

    localparam int MAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Handshake: a byte moves on a rising edge where LOAD_VALID and LOAD_READY are both 1;
    // LOAD_READY is registered and never depends on LOAD_VALID.
    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic                    ready_q, ready_d;
    logic                    cpu_run_q, cpu_run_d;
    logic                    err_q, err_d;
    logic                    fetch_v_q, fetch_oob_q;
    logic                    mem_we;
    logic                    xfer;
    logic                    at_last_addr;
    logic                    fetch_oob;
    logic [INSTRUCTION_WIDTH-1:0] ram_rdata;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
`endif

    assign xfer         = LOAD_VALID && ready_q;
    assign at_last_addr = (ptr_q == ADDR_WIDTH'(MEM_DEPTH - 1));
    assign fetch_oob    = ({1'b0, FETCH_ADDR} >= (ADDR_WIDTH + 1)'(MEM_DEPTH));

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        ptr_d   = ptr_q;
        mem_we  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        // A start request wins over any byte offered in the same cycle.
        if (LOAD_START) begin
            state_d = S_LOAD_HI;
            ptr_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else if (xfer) begin
            case (state_q)
                S_LOAD_HI: begin
                    hi_d    = LOAD_DATA;
                    state_d = LOAD_LAST ? S_ERROR : S_LOAD_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + LOAD_DATA;
`endif
                end
                S_LOAD_LO: begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + ADDR_WIDTH'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + LOAD_DATA;
                    if (LOAD_LAST) state_d = S_LOAD_CSUM;
`else
                    if (LOAD_LAST) state_d = S_RUN;
`endif
                    else if (at_last_addr) state_d = S_ERROR;
                    else state_d = S_LOAD_HI;
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_LOAD_CSUM: begin
                    state_d = (LOAD_DATA == sum_q) ? S_RUN : S_ERROR;
                end
`endif
                default: begin
                    state_d = state_q;
                end
            endcase
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        ready_d = (state_d == S_LOAD_HI) || (state_d == S_LOAD_LO) || (state_d == S_LOAD_CSUM);
`else
        ready_d = (state_d == S_LOAD_HI) || (state_d == S_LOAD_LO);
`endif
        cpu_run_d = (state_d == S_RUN);
        err_d     = (state_d == S_ERROR);
    end

    always_ff @(posedge general_clk or negedge general_reset) begin
        if (!general_reset) begin
            state_q     <= S_IDLE;
            hi_q        <= '0;
            ptr_q       <= '0;
            ready_q     <= 1'b0;
            cpu_run_q   <= 1'b0;
            err_q       <= 1'b0;
            fetch_v_q   <= 1'b0;
            fetch_oob_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            ptr_q       <= ptr_d;
            ready_q     <= ready_d;
            cpu_run_q   <= cpu_run_d;
            err_q       <= err_d;
            fetch_v_q   <= FETCH_REQ && (state_q == S_RUN);
            fetch_oob_q <= fetch_oob;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    prog_mem_ram #(
        .WIDTH(INSTRUCTION_WIDTH),
        .DEPTH(MEM_DEPTH),
        .AW   (MAW)
    ) u_ram (
        .clk_i  (general_clk),
        .we_i   (mem_we),
        .waddr_i(ptr_q[MAW-1:0]),
        .wdata_i({hi_q, LOAD_DATA}),
        .re_i   (FETCH_REQ && (state_q == S_RUN) && !fetch_oob),
        .raddr_i(FETCH_ADDR[MAW-1:0]),
        .rdata_o(ram_rdata)
    );

    // The RAM output register is unreset and may hold stale data; gate it with the registered qualifiers.
    assign FETCH_DATA    = (fetch_v_q && !fetch_oob_q) ? ram_rdata : '0;
    assign FETCH_VALID   = fetch_v_q;
    assign LOAD_READY    = ready_q;
    assign CPU_RESET_OUT = cpu_run_q;
    assign LOAD_ERROR    = err_q;
    assign LOAD_COUNT    = ptr_q;
    assign DBG_STATE     = state_q;

endmodule
